mem_arbiter: RTL
================

# mem_arbiter

Arbitrates the single-port RAM interface of the Pillar core between instruction fetch (IF) and load/store (LS). Each accepted request runs one RAM access, waits a fixed read latency, captures read data and returns a one-cycle acknowledge to the requester. The block sits between the control/fetch logic and the RAM, owning `we_o`, `addr_o` and `data_o`.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `RAM_LAT`, 1, cycles from `addr_o` valid to `data_i` valid; legal range 1..4
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `if_req_i`  in  1  fetch request, level
- `if_addr_i`  in  AW  fetch address
- `if_ack_o`  out  1  one-cycle pulse; `if_data_o` valid in the same cycle
- `if_data_o`  out  DW  fetched word; holds until the next IF ack
- `ls_req_i`  in  1  load/store request, level
- `ls_we_i`  in  1  1 = store, 0 = load
- `ls_addr_i`  in  AW  load/store address
- `ls_wdata_i`  in  DW  store data
- `ls_ack_o`  out  1  one-cycle pulse
- `ls_rdata_o`  out  DW  load data; holds until the next LS ack; unchanged on store ack
- `we_o`  out  1  RAM write enable
- `addr_o`  out  AW  RAM address
- `data_o`  out  DW  RAM write data
- `data_i`  in  DW  RAM read data
- `busy_o`  out  1  high whenever the state is not IDLE

## Operation
- FSM states are IDLE, ACCESS and DONE.
- IDLE: sample the requests. If none is pending, stay in IDLE. Otherwise pick a winner, register its `addr_o`, `data_o` and `we_o` (LS store only), clear the latency counter, and go to ACCESS.
- ACCESS: `addr_o` and `data_o` are held. `we_o` is high only in the first ACCESS cycle, so exactly one write occurs per store. The counter increments each cycle. When the counter equals `RAM_LAT`, capture `data_i` into the winner's data register (loads and fetches only) and go to DONE.
- DONE: pulse the winner's ack, then go to IDLE. The loser's ack stays 0.
- Requester rules:
  - Hold `req`, `addr` and `wdata` stable until the ack cycle.
  - `req` still high in the cycle after ack counts as a new request.
  - A dropped `req` before ack is undefined; the arbiter completes the access anyway.
- Only IDLE evaluates requests. A request arriving mid-access waits; no request is lost.
- Reset, including mid-access: state becomes IDLE and all outputs are 0 (`we_o`, `addr_o`, `data_o`, both acks, both data outputs, `busy_o`). The in-flight access is dropped with no ack. Requesters must reissue.

## Timing
- Request seen in IDLE at cycle 0:
  - `addr_o` and `we_o` valid in cycle 1.
  - `data_i` sampled at the end of cycle 1+`RAM_LAT`.
  - Ack and data valid in cycle 2+`RAM_LAT`.
  - IDLE again in cycle 3+`RAM_LAT`.
- Peak throughput is one access per `RAM_LAT`+3 cycles. With `RAM_LAT`=1, back-to-back requests are acked every 4 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `MEM_ARB_RR_EN` undefined:
  - Fixed priority: LS wins over IF when both request in IDLE.
  - IF can starve under continuous LS traffic. This is acceptable because the pipeline stalls fetch during the memory stage.
- `MEM_ARB_RR_EN` defined:
  - Round-robin using a `last_gnt` flop, updated at each grant.
  - On simultaneous requests, the requester not in `last_gnt` wins. A single requester always wins.
  - Reset sets `last_gnt` = LS, so the first contended grant goes to IF.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, ACCESS, DONE),
  - the grant-id enum (GNT_IF, GNT_LS),
  - the default `AW`/`DW`,
  - the latency counter width (3 bits, enough for `RAM_LAT` ≤ 4).
- One sub-module, `mem_arb_pick`:
  - Inputs: the two requests and an `advance` strobe (IDLE with any request). Output: the winner id.
  - Contains the `last_gnt` flop under `MEM_ARB_RR_EN`; purely combinational otherwise.

## Test plan
All scenarios use `RAM_LAT`=1 and a RAM model with 1-cycle synchronous read.
- Reset check: assert `reset` for 2 cycles with RAM preloaded -> all outputs 0, `busy_o`=0, state IDLE.
- Single fetch: IF req, addr 0x0, RAM[0]=0x00A00093 at cycle 0 -> `addr_o`=0x0 in cycle 1, `if_ack_o` in cycle 3 with `if_data_o`=0x00A00093, `busy_o` high in cycles 1-3.
- Store then load: LS store 0x100 <- 0xDEADBEEF, then load 0x100 -> `we_o` high exactly 1 cycle; load acks 0xDEADBEEF; `ls_rdata_o` unchanged by the store ack.
- Contention: IF and LS both held high from cycle 0 -> without macro, LS acked at cycle 3 and IF at cycle 7. With `MEM_ARB_RR_EN`, IF acked first, then LS, alternating on sustained requests.
- Reset mid-access: LS store issued, `reset` asserted in cycle 1 -> no ack, `we_o`=0 from cycle 2, RAM word unchanged or written once (never twice), IDLE after release.
- Held request: IF holds `req` high across its ack -> second access starts at cycle 4, ack at cycle 7.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the Pillar memory arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration (default is
// fixed priority with load/store ahead of fetch).
package mem_arb_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  // Latency counter width; covers RAM_LAT up to 4.
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/acknowledge channels for fetch and load/store plus the RAM port.
// The arbiter connects through the slave modport; the requesters and the RAM
// model sit on the master side.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_ack_o;
  logic [DW-1:0] if_data_o;

  logic          ls_req_i;
  logic          ls_we_i;
  logic [AW-1:0] ls_addr_i;
  logic [DW-1:0] ls_wdata_i;
  logic          ls_ack_o;
  logic [DW-1:0] ls_rdata_o;

  logic          we_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  logic [DW-1:0] data_i;

  logic          busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    input  data_i,
    output if_ack_o, if_data_o,
    output ls_ack_o, ls_rdata_o,
    output we_o, addr_o, data_o,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
    output data_i,
    input  if_ack_o, if_data_o,
    input  ls_ack_o, ls_rdata_o,
    input  we_o, addr_o, data_o,
    input  busy_o
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and load/store.
// Build option: MEM_ARB_RR_EN adds a last-grant flop for round-robin;
// without it the choice is purely combinational, load/store first.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic if_req,
  input  logic ls_req,
  input  logic advance,
  output gnt_t winner
);

`ifdef MEM_ARB_RR_EN
  gnt_t last_gnt;

  // Remember who was granted last; reset favours fetch on the first contest.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= GNT_LS;
    end else if (advance) begin
      last_gnt <= winner;
    end
  end

  // On a contest the side that did not win last time goes next.
  always_comb begin
    winner = GNT_IF;
    if (if_req && ls_req) begin
      winner = (last_gnt == GNT_LS) ? GNT_IF : GNT_LS;
    end else if (ls_req) begin
      winner = GNT_LS;
    end
  end
`else
  // Load/store always beats fetch; the winner only matters while advancing.
  always_comb begin
    winner = GNT_IF;
    if (advance && ls_req) begin
      winner = GNT_LS;
    end else if (advance && if_req) begin
      winner = GNT_IF;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store.
// One access per grant: drive the RAM, wait RAM_LAT cycles, capture read data,
// then pulse the winner's ack for one cycle. All outputs are registered.
// Build option: MEM_ARB_RR_EN switches the picker to round-robin.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | sample requests; on any request latch winner and RAM command
//   ACCESS | RAM command held; we_o only in first cycle; count to RAM_LAT
//   DONE   | winner's ack pulses with captured data, then back to IDLE
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int RAM_LAT = 1
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(RAM_LAT);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  gnt_t             gnt_q;
  gnt_t             pick_gnt;
  logic             store_q;
  logic             advance;
  logic             capture;

  assign advance = (state_q == IDLE) & (bus.if_req_i | bus.ls_req_i);

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk     (clk),
    .reset   (reset),
`endif
    .if_req  (bus.if_req_i),
    .ls_req  (bus.ls_req_i),
    .advance (advance),
    .winner  (pick_gnt)
  );

  // Next-state: only IDLE looks at requests; ACCESS ends on the latency count.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (advance) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == LAT_C) begin
          state_d = DONE;
          capture = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RAM command, latency counter, read capture and ack pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      gnt_q          <= GNT_IF;
      store_q        <= 1'b0;
      bus.we_o       <= 1'b0;
      bus.addr_o     <= {AW{1'b0}};
      bus.data_o     <= {DW{1'b0}};
      bus.if_ack_o   <= 1'b0;
      bus.if_data_o  <= {DW{1'b0}};
      bus.ls_ack_o   <= 1'b0;
      bus.ls_rdata_o <= {DW{1'b0}};
      bus.busy_o     <= 1'b0;
    end else begin
      // Write strobe and acks are single-cycle pulses.
      bus.we_o     <= 1'b0;
      bus.if_ack_o <= 1'b0;
      bus.ls_ack_o <= 1'b0;
      bus.busy_o   <= (state_d != IDLE);

      if (advance) begin
        gnt_q <= pick_gnt;
        cnt_q <= '0;
        if (pick_gnt == GNT_LS) begin
          bus.addr_o <= bus.ls_addr_i;
          bus.data_o <= bus.ls_wdata_i;
          bus.we_o   <= bus.ls_we_i;
          store_q    <= bus.ls_we_i;
        end else begin
          bus.addr_o <= bus.if_addr_i;
          bus.data_o <= {DW{1'b0}};
          store_q    <= 1'b0;
        end
      end else if (state_q == ACCESS) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (capture) begin
        if (gnt_q == GNT_LS) begin
          bus.ls_ack_o <= 1'b1;
          // A store ack leaves the last load result in place.
          if (!store_q) begin
            bus.ls_rdata_o <= bus.data_i;
          end
        end else begin
          bus.if_ack_o  <= 1'b1;
          bus.if_data_o <= bus.data_i;
        end
      end
    end
  end

endmodule
